// File: rtl/rf_pkg.sv
// Shared defaults, pending-count type and bypass match helper for the
// decode-stage register file with per-register write scoreboard.
package rf_pkg;

  localparam int RF_DATA_W   = 16;
  localparam int RF_NUM_REGS = 16;
  localparam int RF_NUM_RD   = 2;
  localparam int RF_MAX_PEND = 3;
  // Widest register index the bypass helper compares; callers zero-extend.
  localparam int RF_ADDR_MAX = 8;

  typedef logic [1:0] pend_t;

  function automatic logic rf_bypass_sel(
    input logic                   wr_en,
    input logic [RF_ADDR_MAX-1:0] wr_addr,
    input logic [RF_ADDR_MAX-1:0] rd_addr
  );
    return wr_en && (wr_addr == rd_addr);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundle of read ports, writeback, reservation and flush signals between the
// decode/hazard logic (master) and the register file (slave).
interface regfile_scoreboard_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int NUM_RD   = 2,
  parameter int ADDR_W   = $clog2(NUM_REGS)
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_ready;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  // Reservation handshake: rsv_en is the valid, rsv_ack the combinational
  // ready. A reservation transfers only in a cycle where both are high; the
  // requester must hold rsv_en and rsv_addr stable until it sees rsv_ack.
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_ack;
  logic                     flush;
  logic                     wb_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_ready, rsv_ack, wb_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_ready, rsv_ack, wb_err
  );

endinterface

// File: rtl/rf_pend_ctr.sv
// Per-register outstanding-write counter: saturates at MAX_PEND, floors at 0,
// and a simultaneous reserve and release leaves the count unchanged.
module rf_pend_ctr
  import rf_pkg::*;
#(
  parameter int MAX_PEND = RF_MAX_PEND
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  inc_i,
  input  logic  dec_i,
  input  logic  flush_i,
  output pend_t cnt_o,
  output logic  zero_o
);

  pend_t cnt_q, cnt_d;
  logic  dec_eff;

  always_comb begin
    cnt_d   = cnt_q;
    // A release only counts against an outstanding reservation.
    dec_eff = dec_i && (cnt_q != '0);
    if (flush_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_eff) begin
      if (int'(cnt_q) < MAX_PEND) cnt_d = cnt_q + 2'd1;
    end else if (dec_eff && !inc_i) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, same-cycle writeback bypass and
// a per-register pending-write scoreboard driving per-port operand-ready.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int MAX_PEND = RF_MAX_PEND,
  parameter int ZERO_REG = 1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  pend_t               pend   [NUM_REGS];
  logic [NUM_REGS-1:0] pend_zero, inc, dec;
  logic                wb_err_q, wb_err_d;
  logic                wr_live, rsv_is_zero, rsv_room, rsv_ack;
  pend_t               rsv_pend;

  always_comb begin
    wr_live     = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));
    rsv_is_zero = (ZERO_REG != 0) && (bus.rsv_addr == '0);
    rsv_pend    = pend[bus.rsv_addr];
    // A writeback releasing the same register frees one slot this cycle.
    rsv_room    = (int'(rsv_pend) < MAX_PEND) ||
                  (wr_live && (bus.wr_addr == bus.rsv_addr) && (rsv_pend != '0));
    rsv_ack     = bus.rsv_en && !bus.flush && !rst && (rsv_is_zero || rsv_room);
    wb_err_d    = wb_err_q || (wr_live && pend_zero[bus.wr_addr]);
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_pend
    assign inc[i] = rsv_ack && !rsv_is_zero && (bus.rsv_addr == ADDR_W'(i));
    assign dec[i] = wr_live && (bus.wr_addr == ADDR_W'(i));

    rf_pend_ctr #(.MAX_PEND(MAX_PEND)) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (inc[i]),
      .dec_i   (dec[i]),
      .flush_i (bus.flush),
      .cnt_o   (pend[i]),
      .zero_o  (pend_zero[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wb_err_q <= 1'b0;
    end else begin
      if (wr_live) regs_q[bus.wr_addr] <= bus.wr_data;
      wb_err_q <= wb_err_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdata;
    logic              rrdy, byp;

    assign ra = bus.rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      byp   = rf_bypass_sel(bus.wr_en, RF_ADDR_MAX'(bus.wr_addr), RF_ADDR_MAX'(ra));
      rdata = regs_q[ra];
      rrdy  = (pend[ra] == '0);
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rdata = '0;
        rrdy  = 1'b1;
      end else if (byp) begin
        rdata = bus.wr_data;
        rrdy  = (pend[ra] == '0) || (pend[ra] == 2'd1);
      end
    end

    assign bus.rd_data[k*DATA_W +: DATA_W] = rdata;
    assign bus.rd_ready[k]                 = rrdy;
  end

  assign bus.rsv_ack = rsv_ack;
  assign bus.wb_err  = wb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed checks of read/bypass, reservation limits, zero register, flush and
// reset on a default instance and a wide 4-port 32x32 instance.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2)) bus_a ();
  regfile_scoreboard_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(4)) bus_b ();

  regfile_scoreboard u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  regfile_scoreboard #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(4)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_a();
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_a.rsv_en = 1'b0; bus_a.rsv_addr = '0; bus_a.flush = 1'b0;
  endtask

  task automatic idle_b();
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    bus_b.rsv_en = 1'b0; bus_b.rsv_addr = '0; bus_b.flush = 1'b0;
  endtask

  task automatic rd_a(input logic [3:0] a0, input logic [3:0] a1);
    bus_a.rd_addr = {a1, a0};
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [15:0] d);
    bus_a.wr_en = 1'b1; bus_a.wr_addr = a; bus_a.wr_data = d;
  endtask

  task automatic rsv_a(input logic [3:0] a);
    bus_a.rsv_en = 1'b1; bus_a.rsv_addr = a;
  endtask

  initial begin
    // Reset both instances; reservation during reset must not be acked.
    rst_a = 1'b1; rst_b = 1'b1;
    idle_a(); idle_b();
    rd_a(4'd5, 4'd9);
    bus_b.rd_addr = '0;
    rsv_a(4'd3);
    #1 check("ack_in_rst", 32'(bus_a.rsv_ack), 32'd0);
    step();
    rst_a = 1'b0; rst_b = 1'b0;
    idle_a();
    #1;
    check("rst_data0", 32'(bus_a.rd_data[15:0]), 32'h0);
    check("rst_data1", 32'(bus_a.rd_data[31:16]), 32'h0);
    check("rst_ready", 32'(bus_a.rd_ready), 32'h3);
    check("rst_wberr", 32'(bus_a.wb_err), 32'd0);

    // Unreserved write: bypass now, stored next cycle, sticky error.
    wr_a(4'd5, 16'hBEEF);
    #1 check("byp_r5", 32'(bus_a.rd_data[15:0]), 32'hBEEF);
    step(); idle_a();
    #1;
    check("wberr_set", 32'(bus_a.wb_err), 32'd1);
    check("stored_r5", 32'(bus_a.rd_data[15:0]), 32'hBEEF);

    // Reserve r3, then writeback with bypass releases it.
    rsv_a(4'd3);
    #1 check("rsv_r3_ack", 32'(bus_a.rsv_ack), 32'd1);
    step(); idle_a(); rd_a(4'd3, 4'd3);
    #1 check("r3_busy", 32'(bus_a.rd_ready), 32'h0);
    wr_a(4'd3, 16'h1234);
    #1;
    check("r3_byp_data", 32'(bus_a.rd_data[15:0]), 32'h1234);
    check("r3_byp_rdy", 32'(bus_a.rd_ready), 32'h3);
    step(); idle_a();
    #1 check("r3_released", 32'(bus_a.rd_ready), 32'h3);

    // r7: three reservations fill it, a fourth is refused.
    for (int i = 0; i < 3; i++) begin
      rsv_a(4'd7);
      #1 check($sformatf("r7_rsv%0d", i), 32'(bus_a.rsv_ack), 32'd1);
      step();
    end
    rsv_a(4'd7);
    #1 check("r7_full_nack", 32'(bus_a.rsv_ack), 32'd0);
    // Reserve plus writeback of the same register: acked, count stays at 3.
    wr_a(4'd7, 16'h0777);
    #1 check("r7_rsv_wr_ack", 32'(bus_a.rsv_ack), 32'd1);
    step(); idle_a(); rd_a(4'd7, 4'd5);
    wr_a(4'd7, 16'h0001);
    #1 check("r7_pend3", 32'(bus_a.rd_ready[0]), 32'd0);
    step();
    wr_a(4'd7, 16'h0002);
    #1 check("r7_pend2", 32'(bus_a.rd_ready[0]), 32'd0);
    step();
    wr_a(4'd7, 16'h0003);
    #1 check("r7_pend1_byp", 32'(bus_a.rd_ready[0]), 32'd1);
    step(); idle_a();
    #1;
    check("r7_free", 32'(bus_a.rd_ready[0]), 32'd1);
    check("r7_data", 32'(bus_a.rd_data[15:0]), 32'h0003);

    // Zero register ignores writes and reservations.
    rd_a(4'd0, 4'd0);
    wr_a(4'd0, 16'hFFFF);
    #1 check("r0_byp_zero", 32'(bus_a.rd_data[15:0]), 32'h0);
    step(); idle_a();
    #1 check("r0_stored_zero", 32'(bus_a.rd_data[15:0]), 32'h0);
    rsv_a(4'd0);
    #1 check("r0_rsv_ack", 32'(bus_a.rsv_ack), 32'd1);
    step(); idle_a();
    #1 check("r0_ready", 32'(bus_a.rd_ready), 32'h3);

    // Fresh reset, then flush with a concurrent writeback to a reserved register.
    rst_a = 1'b1; step(); rst_a = 1'b0;
    #1 check("wberr_cleared", 32'(bus_a.wb_err), 32'd0);
    rsv_a(4'd2); step();
    rsv_a(4'd4); step(); idle_a();
    rd_a(4'd2, 4'd4);
    #1 check("pre_flush_busy", 32'(bus_a.rd_ready), 32'h0);
    bus_a.flush = 1'b1;
    wr_a(4'd4, 16'h00AA);
    rsv_a(4'd5);
    #1 check("flush_nack", 32'(bus_a.rsv_ack), 32'd0);
    step(); idle_a();
    #1;
    check("flush_ready", 32'(bus_a.rd_ready), 32'h3);
    check("flush_r4", 32'(bus_a.rd_data[31:16]), 32'h00AA);
    check("flush_wberr", 32'(bus_a.wb_err), 32'd0);
    rd_a(4'd5, 4'd5);
    #1 check("flush_r5_free", 32'(bus_a.rd_ready), 32'h3);

    // Reset beats writeback and reservation on the same edge.
    rsv_a(4'd6); step(); idle_a();
    rst_a = 1'b1;
    wr_a(4'd6, 16'h5555);
    rsv_a(4'd6);
    step(); rst_a = 1'b0; idle_a();
    rd_a(4'd6, 4'd6);
    #1;
    check("rst_win_rdy", 32'(bus_a.rd_ready), 32'h3);
    check("rst_win_data", 32'(bus_a.rd_data[15:0]), 32'h0);

    // Wide instance: four ports all bypass a write to r31.
    bus_b.rd_addr = {4{5'd31}};
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 5'd31; bus_b.wr_data = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'hDEADBEEF);
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("b_byp_p%0d", k), bus_b.rd_data[k*32 +: 32], exp_q.pop_front());
    step(); idle_b();
    #1;
    check("b_stored", bus_b.rd_data[127:96], 32'hDEADBEEF);
    check("b_wberr", 32'(bus_b.wb_err), 32'd1);
    bus_b.rsv_en = 1'b1; bus_b.rsv_addr = 5'd31;
    #1 check("b_rsv_ack", 32'(bus_b.rsv_ack), 32'd1);
    step(); idle_b();
    #1 check("b_busy", 32'(bus_b.rd_ready), 32'h0);
    // Reset in the middle of a reservation request.
    rst_b = 1'b1;
    bus_b.rsv_en = 1'b1; bus_b.rsv_addr = 5'd10;
    #1 check("b_rst_nack", 32'(bus_b.rsv_ack), 32'd0);
    step(); rst_b = 1'b0; idle_b();
    bus_b.rd_addr = {5'd10, 5'd31, 5'd10, 5'd31};
    #1;
    check("b_rst_ready", 32'(bus_b.rd_ready), 32'hF);
    check("b_rst_data", bus_b.rd_data[31:0], 32'h0);
    check("b_rst_wberr", 32'(bus_b.wb_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
